addr_region_ctrl: RTL
=====================

ADDR_REGION_CTRL -- requirements
Module: addr_region_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32: address width in bits.
REQ-002 Parameter N_REG, default 4: number of decoded regions, range 1..8.
REQ-003 Parameter WAIT_W, default 4: width of each per-region wait-state count.
REQ-004 Parameter REG_BASE, default {0x00000800, 0x00002000, 0x00001000, 0x00000500}: packed bases, region k at [k*ADDR_W +: ADDR_W].
REQ-005 Parameter REG_LIMIT, default {0x00000BFF, 0x00002FFF, 0x00001FFF, 0x000008FF}: packed inclusive limits, same packing.
REQ-006 Parameter REG_WAIT, default {4'd1, 4'd5, 4'd2, 4'd0}: packed wait states, region k at [k*WAIT_W +: WAIT_W].
REQ-007 CLK  in  1  sole clock, rising edge.
REQ-008 RST  in  1  synchronous, active-high reset.
REQ-009 Address  in  ADDR_W  access address, sampled only on an accepted request.
REQ-010 Req  in  1  access request, one-cycle pulse or level.
REQ-011 CS  out  N_REG  registered one-hot chip select.
REQ-012 Ready  out  1  one-cycle access-complete strobe.
REQ-013 BusErr  out  1  one-cycle unmapped-access strobe.
REQ-014 Busy  out  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and ERR.
REQ-016 Region k SHALL hit when REG_BASE[k] <= Address <= REG_LIMIT[k], unsigned, both bounds inclusive.
REQ-017 Overlapping hits SHALL resolve to the lowest region index.
REQ-018 In IDLE with Req=1 and a hit on k: next cycle state=WAIT, CS=1<<k, counter=REG_WAIT[k].
REQ-019 In WAIT with counter>0: counter decrements by 1; CS held; Ready=0.
REQ-020 In WAIT with counter==0: Ready=1 for that cycle with CS still asserted; next cycle state=IDLE, CS=0.
REQ-021 Req-to-Ready latency SHALL be REG_WAIT[k]+1 cycles; CS SHALL be high for REG_WAIT[k]+1 cycles.
REQ-022 Req SHALL be ignored while Busy=1; no queuing; Address changes while busy have no effect.
REQ-023 A Req in the cycle after Ready (state IDLE) SHALL be accepted normally, allowing back-to-back accesses every REG_WAIT+2 cycles.
REQ-024 In IDLE with Req=1 and no hit: behaviour per REQ-029/REQ-030.
REQ-025 In ERR: BusErr=1, CS=0, Ready=0 for exactly one cycle; next state=IDLE.
REQ-026 Ready and BusErr SHALL never both be 1, and CS SHALL never have more than one bit set.

Reset
REQ-027 On RST=1 at a rising edge: state=IDLE, CS=0, Ready=0, BusErr=0, Busy=0, counter=0; RST overrides Req in the same cycle.
REQ-028 RST asserted mid-access (WAIT or ERR) SHALL abort the access with no Ready or BusErr strobe.

Configuration
REQ-029 With macro ADDR_REGION_MISS_ERR_EN defined: an unmapped Req in IDLE SHALL enter ERR, giving BusErr one cycle after the request.
REQ-030 Without ADDR_REGION_MISS_ERR_EN: an unmapped Req SHALL be ignored (state stays IDLE); BusErr SHALL be tied to 0 and the ERR state omitted.

Verification
REQ-031 Address=0x04FF, Req pulse -> CS=0 throughout; BusErr=1 at cycle +1 with macro; nothing without macro.
REQ-032 Address=0x0500, then separately 0x08FF, Req pulse -> CS=0001 for 1 cycle with Ready=1 at cycle +1; 0x0900 -> CS=1000, Ready at cycle +2.
REQ-033 Address=0x0800 (overlap of regions 0 and 3) -> CS=0001 (priority), Ready at cycle +1.
REQ-034 Address=0x2000, Req held high for 10 cycles -> CS=0100 for 6 cycles, Ready at cycle +6, second access accepted at cycle +7, second Ready at cycle +13.
REQ-035 Address=0x1FFF, Req pulse, RST=1 at cycle +2 -> all outputs 0 from cycle +3; no Ready strobe.
REQ-036 Address=0x1000 accepted, Address changed to 0x9000 and Req pulsed at cycle +1 -> CS stays 0010, Ready at cycle +3, no BusErr.

Source files
------------

// File: rtl/addr_region_ctrl.sv
// rtl/addr_region_ctrl.sv - address region decoder with per-region wait states and chip select
// Optional feature macro: ADDR_REGION_MISS_ERR_EN (unmapped requests raise a one-cycle BusErr)

module addr_region_ctrl #(
  parameter int                        ADDR_W    = 32,
  parameter int                        N_REG     = 4,
  parameter int                        WAIT_W    = 4,
  parameter logic [N_REG*ADDR_W-1:0]   REG_BASE  = {32'h0000_0800, 32'h0000_2000,
                                                    32'h0000_1000, 32'h0000_0500},
  parameter logic [N_REG*ADDR_W-1:0]   REG_LIMIT = {32'h0000_0BFF, 32'h0000_2FFF,
                                                    32'h0000_1FFF, 32'h0000_08FF},
  parameter logic [N_REG*WAIT_W-1:0]   REG_WAIT  = {4'd1, 4'd5, 4'd2, 4'd0}
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] Address,
  input  logic              Req,
  output logic [N_REG-1:0]  CS,
  output logic              Ready,
  output logic              BusErr,
  output logic              Busy
);

`ifdef ADDR_REGION_MISS_ERR_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [N_REG-1:0]    cs_q, cs_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;

  logic [N_REG-1:0]    hit;
  logic                hit_any;
  logic [N_REG-1:0]    cs_sel;
  logic [WAIT_W-1:0]   wait_sel;

  // Per-region inclusive range compare, unsigned
  always_comb begin
    hit = '0;
    for (int k = 0; k < N_REG; k++) begin
      hit[k] = (Address >= REG_BASE[k*ADDR_W +: ADDR_W]) &&
               (Address <= REG_LIMIT[k*ADDR_W +: ADDR_W]);
    end
  end

  // Priority select: walk from the top so the lowest hitting index wins
  always_comb begin
    hit_any  = 1'b0;
    cs_sel   = '0;
    wait_sel = '0;
    for (int k = N_REG - 1; k >= 0; k--) begin
      if (hit[k]) begin
        hit_any   = 1'b1;
        cs_sel    = '0;
        cs_sel[k] = 1'b1;
        wait_sel  = REG_WAIT[k*WAIT_W +: WAIT_W];
      end
    end
  end

  // State, chip select and wait counter registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cs_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: accept only in IDLE, so Req and Address are ignored while busy
  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cs_d = '0;
        if (Req && hit_any) begin
          state_d = S_WAIT;
          cs_d    = cs_sel;
          cnt_d   = wait_sel;
        end
`ifdef ADDR_REGION_MISS_ERR_EN
        else if (Req) begin
          state_d = S_ERR;
          cnt_d   = '0;
        end
`endif
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          cs_d    = '0;
        end else begin
          cnt_d = cnt_q - WAIT_W'(1);
        end
      end
`ifdef ADDR_REGION_MISS_ERR_EN
      S_ERR: begin
        state_d = S_IDLE;
        cs_d    = '0;
        cnt_d   = '0;
      end
`endif
      default: begin
        state_d = S_IDLE;
        cs_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: strobes decoded from the registered state, so they drop on the same edge as reset
  always_comb begin
    Ready  = (state_q == S_WAIT) && (cnt_q == '0);
    Busy   = (state_q != S_IDLE);
`ifdef ADDR_REGION_MISS_ERR_EN
    BusErr = (state_q == S_ERR);
`else
    BusErr = 1'b0;
`endif
  end

  assign CS = cs_q;

endmodule
